// File: rtl/avalon_sysctrl_rstbank.sv
// Avalon-MM sysctrl slave: NUM_RST pulse/level reset requests, sticky DONE + irq, scratch reg and RAM.
// Fixed 1-cycle read latency, no waitrequest; clken=0 freezes all state, counters and readdatavalid.
module avalon_sysctrl_rstbank #(
  parameter int ADDR_W        = 8,
  parameter int NUM_RST       = 4,
  parameter int RAM_DEPTH     = 128,
  parameter int PULSE_DEFAULT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  input  logic [ADDR_W-1:0]  address,
  input  logic [3:0]         byteenable,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               readdatavalid,
  output logic [NUM_RST-1:0] rst_req,
  output logic               irq
);
  localparam int          RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [31:0] RAM_BASE = 32'd16;
  localparam logic [31:0] RAM_END  = 32'(16 + RAM_DEPTH);

  logic               wr_en, rd_en, is_ram;
  logic [31:0]        addr_w, wmask, rd_mux, reg_rd, ram_q;
  logic [RAM_AW-1:0]  ram_idx;
  logic               sel_ram;
  logic               wr_ctrl, wr_mode, wr_plen, wr_done, wr_ie, wr_scr;

  logic [NUM_RST-1:0] rst_q, rst_d, mode_q, mode_d, done_q, done_set, ie_q;
  logic [NUM_RST-1:0] wd_n, wm_n;
  logic [15:0]        cnt_q [NUM_RST];
  logic [15:0]        cnt_d [NUM_RST];
  logic [15:0]        plen_q, plen_eff;
  logic [31:0]        scratch_q;
  logic [31:0]        mem [RAM_DEPTH];

  // Write has priority: read+write in the same cycle is a write only.
  assign wr_en   = chipselect & clken & write;
  assign rd_en   = chipselect & clken & read & ~write;
  assign addr_w  = 32'(address);
  assign is_ram  = (addr_w >= RAM_BASE) && (addr_w < RAM_END);
  assign ram_idx = RAM_AW'(addr_w - RAM_BASE);
  assign wmask   = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};

  assign wr_ctrl = wr_en && (addr_w == 32'd0);
  assign wr_mode = wr_en && (addr_w == 32'd1);
  assign wr_plen = wr_en && (addr_w == 32'd2);
  assign wr_done = wr_en && (addr_w == 32'd3);
  assign wr_ie   = wr_en && (addr_w == 32'd4);
  assign wr_scr  = wr_en && (addr_w == 32'd5);

  assign wd_n     = writedata[NUM_RST-1:0];
  assign wm_n     = wmask[NUM_RST-1:0];
  assign mode_d   = (mode_q & ~wm_n) | (wd_n & wm_n);
  assign plen_eff = (plen_q == 16'd0) ? 16'd1 : plen_q;

  // Per-channel next state; only applied on clken edges.
  always_comb begin
    for (int i = 0; i < NUM_RST; i++) begin
      rst_d[i]    = rst_q[i];
      cnt_d[i]    = cnt_q[i];
      done_set[i] = 1'b0;
      if (cnt_q[i] != 16'd0) begin
        cnt_d[i] = cnt_q[i] - 16'd1;
        if (cnt_q[i] == 16'd1) begin
          rst_d[i]    = 1'b0;
          done_set[i] = 1'b1;
        end
      end
      if (wr_ctrl && wm_n[i]) begin
        if (mode_q[i]) begin
          rst_d[i] = wd_n[i];
        end else if (wd_n[i]) begin
          cnt_d[i]    = plen_eff;
          rst_d[i]    = 1'b1;
          done_set[i] = 1'b0;
        end
      end
      // A mode flip abandons the channel silently, without a DONE.
      if (wr_mode && (mode_d[i] != mode_q[i])) begin
        rst_d[i]    = 1'b0;
        cnt_d[i]    = 16'd0;
        done_set[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_w)
      32'd0:   rd_mux = 32'(rst_q);
      32'd1:   rd_mux = 32'(mode_q);
      32'd2:   rd_mux = {16'd0, plen_q};
      32'd3:   rd_mux = 32'(done_q);
      32'd4:   rd_mux = 32'(ie_q);
      32'd5:   rd_mux = scratch_q;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q         <= '0;
      mode_q        <= '0;
      done_q        <= '0;
      ie_q          <= '0;
      plen_q        <= 16'(PULSE_DEFAULT);
      scratch_q     <= '0;
      reg_rd        <= '0;
      sel_ram       <= 1'b0;
      readdatavalid <= 1'b0;
      for (int i = 0; i < NUM_RST; i++) cnt_q[i] <= '0;
    end else if (clken) begin
      rst_q <= rst_d;
      cnt_q <= cnt_d;
      if (wr_mode) mode_q <= mode_d;
      if (wr_ie)   ie_q   <= (ie_q & ~wm_n) | (wd_n & wm_n);
      if (wr_plen) plen_q <= (plen_q & ~wmask[15:0]) | (writedata[15:0] & wmask[15:0]);
      if (wr_scr)  scratch_q <= (scratch_q & ~wmask) | (writedata & wmask);
      // Set beats clear when expiry and write-1-to-clear coincide.
      done_q <= (done_q & ~(wr_done ? (wd_n & wm_n) : '0)) | done_set;
      readdatavalid <= rd_en;
      if (rd_en)            sel_ram <= is_ram;
      if (rd_en && !is_ram) reg_rd  <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (clken) begin
      if (wr_en && is_ram) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) mem[ram_idx][8*b +: 8] <= writedata[8*b +: 8];
      end
      if (rd_en && is_ram) ram_q <= mem[ram_idx];
    end
  end

  assign readdata = sel_ram ? ram_q : reg_rd;
  assign rst_req  = rst_q;
  assign irq      = |(done_q & ie_q);
endmodule
